// File: rtl/hhmmss_keeper.sv
// Time-of-day keeper: 1 Hz prescaler, binary hr/min/sec with set-mode button editing, enb advance strobe.
// Optional per-bit button debounce when HHMMSS_DEBOUNCE_EN is defined (adds the DEB_CYCLES parameter).
module hhmmss_keeper #(
    parameter int CLK_DIV    = 100_000_000
`ifdef HHMMSS_DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES = 1_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw1,
    input  logic [3:0] btn,
    output logic [5:0] hr,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       enb
);

    localparam logic [31:0] PRE_LAST = 32'(CLK_DIV - 1);
    localparam logic [31:0] PRE_ENB  = 32'(CLK_DIV - 2);

    logic [31:0] r_pre;
    logic [3:0]  r_btn_q;
    logic [3:0]  w_btn;
    logic [3:0]  w_edge;

`ifdef HHMMSS_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    for (genvar g = 0; g < 4; g++) begin : g_deb
        logic [DEB_W-1:0] r_cnt;
        logic             r_flt;

        // The filtered level flips only after DEB_CYCLES consecutive disagreeing samples.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
                r_flt <= 1'b0;
            end else if (btn[g] == r_flt) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                r_cnt <= '0;
                r_flt <= btn[g];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_btn[g] = r_flt;
    end
`else
    assign w_btn = btn;
`endif

    assign w_edge = w_btn & ~r_btn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre   <= '0;
            r_btn_q <= '0;
            enb     <= 1'b0;
            hr      <= '0;
            min     <= '0;
            sec     <= '0;
        end else begin
            r_btn_q <= w_btn;
            if (sw1 || r_pre == PRE_LAST)
                r_pre <= '0;
            else
                r_pre <= r_pre + 32'd1;
            // Registered one cycle early so enb lines up with pre == CLK_DIV-1.
            enb <= !sw1 && (r_pre == PRE_ENB);

            if (enb) begin
                if (sec == 6'd59) begin
                    sec <= '0;
                    if (min == 6'd59) begin
                        min <= '0;
                        hr  <= (hr == 6'd23) ? 6'd0 : hr + 6'd1;
                    end else begin
                        min <= min + 6'd1;
                    end
                end else begin
                    sec <= sec + 6'd1;
                end
            end else if (sw1) begin
                if (w_edge[0] && !w_edge[3])
                    min <= (min == 6'd59) ? 6'd0 : min + 6'd1;
                else if (w_edge[3] && !w_edge[0])
                    min <= (min == 6'd0) ? 6'd59 : min - 6'd1;
                if (w_edge[1])
                    hr <= (hr == 6'd23) ? 6'd0 : hr + 6'd1;
                if (w_edge[2])
                    sec <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hhmmss_keeper.sv
// Self-checking bench for hhmmss_keeper: seconds-of-day reference model, directed and random stimulus.
`timescale 1ns/1ps
module tb_hhmmss_keeper;

    localparam int CLK_DIV = 4;
    localparam int DEB     = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw1 = 1'b0;
    logic [3:0] btn = 4'd0;
    logic [5:0] hr, min, sec;
    logic       enb;

    hhmmss_keeper #(
        .CLK_DIV(CLK_DIV)
`ifdef HHMMSS_DEBOUNCE_EN
        , .DEB_CYCLES(DEB)
`endif
    ) dut (
        .clk(clk), .rst(rst), .sw1(sw1), .btn(btn),
        .hr(hr), .min(min), .sec(sec), .enb(enb)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: time as seconds of day, enb from count of consecutive run-mode edges.
    int         m_t   = 0;
    int         m_run = 0;
    bit         m_enb = 1'b0;
    logic [3:0] m_bq  = 4'd0;
    logic [3:0] m_e;
    int         m_h, m_m, m_s;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0; m_run = 0; m_enb = 1'b0; m_bq = 4'd0;
        end else begin
            m_e  = btn & ~m_bq;
            m_bq = btn;
            if (m_enb) begin
                m_t = (m_t + 1) % 86400;
            end else if (sw1) begin
                m_h = m_t / 3600; m_m = (m_t / 60) % 60; m_s = m_t % 60;
                if (m_e[0] && !m_e[3]) m_m = (m_m + 1) % 60;
                if (m_e[3] && !m_e[0]) m_m = (m_m + 59) % 60;
                if (m_e[1]) m_h = (m_h + 1) % 24;
                if (m_e[2]) m_s = 0;
                m_t = m_h * 3600 + m_m * 60 + m_s;
            end
            m_run = sw1 ? 0 : m_run + 1;
            m_enb = (m_run % CLK_DIV) == CLK_DIV - 1;
        end
    end

    logic [18:0] exp_v;
    wire  [18:0] got_v = {hr, min, sec, enb};
    always_comb exp_v = {6'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60), m_enb};

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; sw1 = 1'b0; btn = 4'd0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic press(input int b, input int hold);
        btn[b] = 1'b1;
        repeat (hold) @(negedge clk);
        btn[b] = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_chk++;
        if (got_v !== 19'd0) begin
            n_fail++; $display("FAIL reset_state: got %h want 0", got_v);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL reset_run cyc %0d: got %h want %h", i, got_v, exp_v);
            end
            n_chk++;
            if (enb !== (i % CLK_DIV == CLK_DIV - 1)) begin
                n_fail++; $display("FAIL enb_period cyc %0d: got %b", i, enb);
            end
            if (i == CLK_DIV) begin
                n_chk++;
                if (sec !== 6'd1) begin
                    n_fail++; $display("FAIL first_sec: got %0d want 1", sec);
                end
            end
        end
    endtask

    task automatic test_rollover();
        bit prev_roll = 1'b0;
        int rolls = 0;
        do_reset();
        sw1 = 1'b1;
        for (int i = 0; i < 23; i++) press(1, $urandom_range(1, 3));
        press(3, $urandom_range(1, 3));
        n_chk++;
        if ({hr, min, sec} !== {6'd23, 6'd59, 6'd0}) begin
            n_fail++; $display("FAIL set_2359: got %0d:%0d:%0d want 23:59:0", hr, min, sec);
        end
        sw1 = 1'b0;
        for (int i = 0; i < 62 * CLK_DIV; i++) begin
            @(negedge clk);
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL roll_run cyc %0d: got %h want %h", i, got_v, exp_v);
            end
            if (prev_roll) begin
                rolls++;
                n_chk++;
                if (got_v !== 19'd0) begin
                    n_fail++; $display("FAIL day_wrap: got %h want 0", got_v);
                end
            end
            prev_roll = (hr == 6'd23) && (min == 6'd59) && (sec == 6'd59) && enb;
        end
        n_chk++;
        if (rolls != 1) begin
            n_fail++; $display("FAIL day_wrap_count: got %0d want 1", rolls);
        end
    endtask

    task automatic test_carry();
        do_reset();
        for (int i = 0; i < 64 * CLK_DIV; i++) begin
            @(negedge clk);
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL carry_min cyc %0d: got %h want %h", i, got_v, exp_v);
            end
        end
        n_chk++;
        if ({hr, min, sec} !== {6'd0, 6'd1, 6'd4}) begin
            n_fail++; $display("FAIL carry_min_end: got %0d:%0d:%0d want 0:1:4", hr, min, sec);
        end
        do_reset();
        sw1 = 1'b1;
        press(3, 1);
        sw1 = 1'b0;
        for (int i = 0; i < 64 * CLK_DIV; i++) begin
            @(negedge clk);
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL carry_hr cyc %0d: got %h want %h", i, got_v, exp_v);
            end
        end
        n_chk++;
        if ({hr, min, sec} !== {6'd1, 6'd0, 6'd4}) begin
            n_fail++; $display("FAIL carry_hr_end: got %0d:%0d:%0d want 1:0:4", hr, min, sec);
        end
    endtask

    task automatic test_set_buttons();
        do_reset();
        sw1 = 1'b1;
        btn = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_chk++;
            if (got_v !== exp_v || enb !== 1'b0) begin
                n_fail++; $display("FAIL hold_dec cyc %0d: got %h want %h", i, got_v, exp_v);
            end
        end
        btn = 4'd0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (min !== 6'd59) begin
            n_fail++; $display("FAIL min_wrap_down: got %0d want 59", min);
        end
        press(0, 2);
        n_chk++;
        if ({hr, min} !== {6'd0, 6'd0}) begin
            n_fail++; $display("FAIL min_wrap_up: got %0d:%0d want 0:0", hr, min);
        end
        btn = 4'b1001;
        repeat (2) @(negedge clk);
        btn = 4'd0;
        @(negedge clk);
        n_chk++;
        if (min !== 6'd0) begin
            n_fail++; $display("FAIL min_both: got %0d want 0", min);
        end
        for (int i = 0; i < 80; i++) begin
            btn = 4'($urandom_range(0, 15));
            @(negedge clk);
            n_chk++;
            if (got_v !== exp_v || enb !== 1'b0) begin
                n_fail++; $display("FAIL set_rand cyc %0d: got %h want %h", i, got_v, exp_v);
            end
        end
        btn = 4'd0;
    endtask

    task automatic test_run_reset();
        do_reset();
        sw1 = 1'b1;
        for (int i = 0; i < 12; i++) press(1, 1);
        for (int i = 0; i < 34; i++) press(0, $urandom_range(1, 2));
        sw1 = 1'b0;
        repeat (56 * CLK_DIV) @(negedge clk);
        n_chk++;
        if ({hr, min, sec} !== {6'd12, 6'd34, 6'd56}) begin
            n_fail++; $display("FAIL run_123456: got %0d:%0d:%0d want 12:34:56", hr, min, sec);
        end
        press(1, 2);
        n_chk++;
        if (hr !== 6'd12 || got_v !== exp_v) begin
            n_fail++; $display("FAIL run_btn_ignored: got %h want %h", got_v, exp_v);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (got_v !== 19'd0) begin
            n_fail++; $display("FAIL async_reset: got %h want 0", got_v);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL post_reset cyc %0d: got %h want %h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) sw1 = ~sw1;
            if ($urandom_range(0, 2) == 0) btn = 4'($urandom_range(0, 15));
            @(negedge clk);
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL random cyc %0d: got %h want %h", i, got_v, exp_v);
            end
        end
        sw1 = 1'b0; btn = 4'd0;
    endtask

`ifdef HHMMSS_DEBOUNCE_EN
    task automatic test_debounce();
        do_reset();
        sw1 = 1'b1;
        btn[0] = 1'b1;
        repeat (DEB - 1) @(negedge clk);
        btn[0] = 1'b0;
        repeat (6) @(negedge clk);
        n_chk++;
        if (min !== 6'd0) begin
            n_fail++; $display("FAIL deb_glitch: got %0d want 0", min);
        end
        btn[0] = 1'b1;
        repeat (DEB + 2) @(negedge clk);
        btn[0] = 1'b0;
        repeat (8) @(negedge clk);
        n_chk++;
        if ({hr, min, sec} !== {6'd0, 6'd1, 6'd0}) begin
            n_fail++; $display("FAIL deb_press: got %0d:%0d:%0d want 0:1:0", hr, min, sec);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef HHMMSS_DEBOUNCE_EN
        test_debounce();
`else
        test_rollover();
        test_carry();
        test_set_buttons();
        test_run_reset();
        test_random();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
